// File: rtl/acl2_pkg.sv
// Shared constants, types and helpers for the ADXL362 register-model responder.
// ACL2_RESP_SIGN_EXT_EN selects sign replication into the high data byte nibble.
package acl2_pkg;

    localparam logic [7:0] CMD_WR = 8'h0A;
    localparam logic [7:0] CMD_RD = 8'h0B;

    localparam logic [7:0] ADDR_DEVID_AD   = 8'h00;
    localparam logic [7:0] ADDR_DEVID_MST  = 8'h01;
    localparam logic [7:0] ADDR_PARTID     = 8'h02;
    localparam logic [7:0] ADDR_XDATA_L    = 8'h0E;
    localparam logic [7:0] ADDR_XDATA_H    = 8'h0F;
    localparam logic [7:0] ADDR_YDATA_L    = 8'h10;
    localparam logic [7:0] ADDR_YDATA_H    = 8'h11;
    localparam logic [7:0] ADDR_ZDATA_L    = 8'h12;
    localparam logic [7:0] ADDR_ZDATA_H    = 8'h13;
    localparam logic [7:0] ADDR_SOFT_RESET = 8'h1F;
    localparam logic [7:0] ADDR_FILTER_CTL = 8'h2C;
    localparam logic [7:0] ADDR_POWER_CTL  = 8'h2D;

    localparam logic [7:0] DEVID_AD_VAL   = 8'hAD;
    localparam logic [7:0] PARTID_VAL     = 8'hF2;
    localparam logic [7:0] FILTER_CTL_RST = 8'h13;
    localparam logic [7:0] POWER_CTL_RST  = 8'h00;
    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
    localparam logic [1:0] MODE_MEASURE   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD,
        ST_WR,
        ST_IGN
    } state_e;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] z;
    } xyz_t;

    function automatic logic [7:0] hi_byte(input logic [11:0] s);
`ifdef ACL2_RESP_SIGN_EXT_EN
        return {{4{s[11]}}, s[11:8]};
`else
        return {4'h0, s[11:8]};
`endif
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes SCLK/MOSI/CS into the system clock domain and produces
// single-cycle SCLK rise/fall and CS fall/rise pulses.
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk_i,
    input  logic mosi_i,
    input  logic cs_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic cs_fall_o,
    output logic cs_rise_o,
    output logic mosi_o,
    output logic busy_o
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;
    logic                   armed_q;
    logic                   sclk_s;
    logic                   cs_s;

    // CS chain resets low so a CS held low across reset release never
    // produces a falling edge; a real high must be seen first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            armed_q     <= armed_q | cs_s;
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_o      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise_o = sclk_s & ~sclk_prev_q;
    assign sclk_fall_o = ~sclk_s & sclk_prev_q;
    assign cs_fall_o   = cs_prev_q & ~cs_s;
    assign cs_rise_o   = cs_s & ~cs_prev_q;
    assign busy_o      = armed_q & ~cs_s;

endmodule

// File: rtl/acl2_spi_responder.sv
// SPI mode-0 responder modelling the ADXL362 register interface (PmodACL2).
// Build option: ACL2_RESP_SIGN_EXT_EN sign-extends the high data bytes.
module acl2_spi_responder
    import acl2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID_MST   = 8'h1D
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sclk_i,
    input  logic        mosi_i,
    input  logic        cs_i,
    output logic        miso_o,
    input  logic [11:0] sample_x_i,
    input  logic [11:0] sample_y_i,
    input  logic [11:0] sample_z_i,
    input  logic        sample_valid_i,
    output logic [7:0]  power_ctl_o,
    output logic [7:0]  filter_ctl_o,
    output logic        wr_pulse_o,
    output logic        busy_o
);

    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;
    logic mosi_s;

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sclk_i      (sclk_i),
        .mosi_i      (mosi_i),
        .cs_i        (cs_i),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .cs_fall_o   (cs_fall),
        .cs_rise_o   (cs_rise),
        .mosi_o      (mosi_s),
        .busy_o      (busy_o)
    );

    state_e      state_q,   state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q,   shift_d;
    logic [7:0]  addr_q,    addr_d;
    logic [7:0]  tx_q,      tx_d;
    logic        is_rd_q,   is_rd_d;
    logic        miso_q,    miso_d;
    logic [7:0]  power_q,   power_d;
    logic [7:0]  filter_q,  filter_d;
    logic        wr_pulse_q, wr_pulse_d;
    xyz_t        hold_q,    hold_d;
    xyz_t        snap_q,    snap_d;
    logic [7:0]  rx_byte;

    function automatic logic [7:0] reg_read(
        input logic [7:0] a,
        input xyz_t       s,
        input logic [7:0] pwr,
        input logic [7:0] flt
    );
        logic [7:0] v;
        v = 8'h00;
        case (a)
            ADDR_DEVID_AD:   v = DEVID_AD_VAL;
            ADDR_DEVID_MST:  v = DEVID_MST;
            ADDR_PARTID:     v = PARTID_VAL;
            ADDR_XDATA_L:    v = s.x[7:0];
            ADDR_XDATA_H:    v = hi_byte(s.x);
            ADDR_YDATA_L:    v = s.y[7:0];
            ADDR_YDATA_H:    v = hi_byte(s.y);
            ADDR_ZDATA_L:    v = s.z[7:0];
            ADDR_ZDATA_H:    v = hi_byte(s.z);
            ADDR_FILTER_CTL: v = flt;
            ADDR_POWER_CTL:  v = pwr;
            default:         v = 8'h00;
        endcase
        return v;
    endfunction

    assign rx_byte = {shift_q, mosi_s};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        is_rd_d    = is_rd_q;
        miso_d     = miso_q;
        power_d    = power_q;
        filter_d   = filter_q;
        wr_pulse_d = 1'b0;
        hold_d     = hold_q;
        snap_d     = snap_q;

        if (sample_valid_i && (power_q[1:0] == MODE_MEASURE)) begin
            hold_d = '{x: sample_x_i, y: sample_y_i, z: sample_z_i};
        end

        if (cs_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            snap_d    = hold_q;
        end else if (cs_rise) begin
            state_d = ST_IDLE;
        end else if (state_q != ST_IDLE) begin
            if (sclk_rise) begin
                shift_d   = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    unique case (state_q)
                        ST_CMD: begin
                            if (rx_byte == CMD_RD) begin
                                state_d = ST_ADDR;
                                is_rd_d = 1'b1;
                            end else if (rx_byte == CMD_WR) begin
                                state_d = ST_ADDR;
                                is_rd_d = 1'b0;
                            end else begin
                                state_d = ST_IGN;
                            end
                        end
                        ST_ADDR: begin
                            addr_d = rx_byte;
                            if (is_rd_q) begin
                                state_d = ST_RD;
                                tx_d    = reg_read(rx_byte, snap_q, power_q, filter_q);
                            end else begin
                                state_d = ST_WR;
                            end
                        end
                        ST_RD: begin
                            addr_d = addr_q + 8'd1;
                            tx_d   = reg_read(addr_q + 8'd1, snap_q, power_q, filter_q);
                        end
                        ST_WR: begin
                            addr_d = addr_q + 8'd1;
                            case (addr_q)
                                ADDR_FILTER_CTL: begin
                                    filter_d   = rx_byte;
                                    wr_pulse_d = 1'b1;
                                end
                                ADDR_POWER_CTL: begin
                                    power_d    = rx_byte;
                                    wr_pulse_d = 1'b1;
                                end
                                ADDR_SOFT_RESET: begin
                                    wr_pulse_d = 1'b1;
                                    if (rx_byte == SOFT_RESET_KEY) begin
                                        power_d  = POWER_CTL_RST;
                                        filter_d = FILTER_CTL_RST;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
            end else if (sclk_fall) begin
                // After the 8th rise bit_cnt is 0, so this presents the next byte's MSB.
                miso_d = (state_q == ST_RD) ? tx_q[3'd7 - bit_cnt_q] : 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            tx_q       <= '0;
            is_rd_q    <= 1'b0;
            miso_q     <= 1'b0;
            power_q    <= POWER_CTL_RST;
            filter_q   <= FILTER_CTL_RST;
            wr_pulse_q <= 1'b0;
            hold_q     <= '0;
            snap_q     <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            is_rd_q    <= is_rd_d;
            miso_q     <= miso_d;
            power_q    <= power_d;
            filter_q   <= filter_d;
            wr_pulse_q <= wr_pulse_d;
            hold_q     <= hold_d;
            snap_q     <= snap_d;
        end
    end

    assign miso_o       = miso_q;
    assign power_ctl_o  = power_q;
    assign filter_ctl_o = filter_q;
    assign wr_pulse_o   = wr_pulse_q;

endmodule
